// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator operand-entry controller.
package calc_pkg;

   localparam logic [3:0] OP_MUL    = 4'd1;
   localparam logic [3:0] OP_ADD    = 4'd2;
   localparam logic [3:0] OP_SUB    = 4'd3;
   localparam logic [3:0] OP_DIV    = 4'd4;
   localparam logic [3:0] OP_EQ     = 4'd14;
   localparam logic [3:0] DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      REQ     = 2'd2,
      SHOW    = 2'd3
   } state_e;

   // True for the four arithmetic operators (mul/add/sub/div).
   function automatic logic is_arith_op(input logic [3:0] code);
      return (code >= OP_MUL) && (code <= OP_DIV);
   endfunction

endpackage

// File: rtl/click_edge_detect.sv
// Turns the decoder's level-style click flag into a single-cycle event pulse.
module click_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic hit,
   output logic click_evt
);

   logic hit_q;
   logic hit_d;

   // Next value of the delayed click level.
   always_comb begin
      hit_d = hit;
   end

   // Delayed click level; a new event needs hit low for at least one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_q <= 1'b0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign click_evt = hit & ~hit_q;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Operand-entry controller: accumulates two decimal operands and an operator,
// issues a req/ack transaction to the ALU and selects the displayed value.
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned MAX_DIGITS = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              newDigit,
   input  logic              newOp,
   input  logic [3:0]        clickedMatrix,
   output logic              calc_req,
   output logic [DATA_W-1:0] calc_a,
   output logic [DATA_W-1:0] calc_b,
   output logic [3:0]        calc_op,
   input  logic              calc_ack,
   input  logic [DATA_W-1:0] calc_result,
   output logic [DATA_W-1:0] disp_value,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
   logic [CNT_W-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic [3:0]          op_q, op_d;
   logic                req_q, req_d;

   logic                click_evt;
   logic                digit_evt, op_evt, eq_evt;
   logic [DATA_W-1:0]   digit_val, a_app, b_app;

   click_edge_detect u_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .hit       (newDigit | newOp),
      .click_evt (click_evt)
   );

   // Event classification and next-state / datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      a_cnt_d = a_cnt_q;
      b_cnt_d = b_cnt_q;
      op_d    = op_q;
      res_d   = res_q;

      // newOp has priority when both decoder flags are high
      digit_evt = click_evt & newDigit & ~newOp & (clickedMatrix <= DIGIT_MAX);
      op_evt    = click_evt & newOp & is_arith_op(clickedMatrix);
      eq_evt    = click_evt & newOp & (clickedMatrix == OP_EQ);

      digit_val = DATA_W'(clickedMatrix);
      a_app     = (a_q << 3) + (a_q << 1) + digit_val;
      b_app     = (b_q << 3) + (b_q << 1) + digit_val;

      unique case (state_q)
         ENTER_A: begin
            if (digit_evt) begin
               if (a_cnt_q < CNT_MAX) begin
                  a_d     = a_app;
                  a_cnt_d = a_cnt_q + 1'b1;
               end
            end else if (op_evt) begin
               op_d    = clickedMatrix;
               b_d     = '0;
               b_cnt_d = '0;
               state_d = ENTER_B;
            end
         end
         ENTER_B: begin
            if (digit_evt) begin
               if (b_cnt_q < CNT_MAX) begin
                  b_d     = b_app;
                  b_cnt_d = b_cnt_q + 1'b1;
               end
            end else if (op_evt) begin
               if (b_cnt_q == '0) op_d = clickedMatrix;
            end else if (eq_evt) begin
               if (b_cnt_q != '0) state_d = REQ;
            end
         end
         REQ: begin
            if (calc_ack) begin
               res_d   = calc_result;
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (digit_evt) begin
               a_d     = digit_val;
               a_cnt_d = CNT_W'(1);
               state_d = ENTER_A;
            end else if (op_evt) begin
               // chained result is full-width: no further digits append onto it
               a_d     = res_q;
               a_cnt_d = CNT_MAX;
               op_d    = clickedMatrix;
               b_d     = '0;
               b_cnt_d = '0;
               state_d = ENTER_B;
            end
         end
         default: state_d = ENTER_A;
      endcase

      // Outputs are decoded from next-state values so they register together.
      req_d = (state_d == REQ);
      unique case (state_d)
         ENTER_B: disp_d = (b_cnt_d != '0) ? b_d : a_d;
         SHOW:    disp_d = res_d;
         default: disp_d = a_d;
      endcase
   end

   // State, operand, result and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ENTER_A;
         a_q     <= '0;
         b_q     <= '0;
         a_cnt_q <= '0;
         b_cnt_q <= '0;
         op_q    <= '0;
         res_q   <= '0;
         disp_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         a_cnt_q <= a_cnt_d;
         b_cnt_q <= b_cnt_d;
         op_q    <= op_d;
         res_q   <= res_d;
         disp_q  <= disp_d;
         req_q   <= req_d;
      end
   end

   assign calc_req   = req_q;
   assign busy       = req_q;
   assign calc_a     = a_q;
   assign calc_b     = b_q;
   assign calc_op    = op_q;
   assign disp_value = disp_q;

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Operand-entry controller directly downstream of the click decoder. Consumes the decoder's level-style `newDigit`/`newOp`/`clickedMatrix` outputs and turns each new click into exactly one event. Accumulates two decimal operands and an operator, then issues a request/acknowledge transaction to the arithmetic unit. Drives the value shown on the calculator display.

## Interface
- `DATA_W`, 16: operand/result width in bits, unsigned.
- `MAX_DIGITS`, 4: maximum decimal digits per operand. Requires 10^MAX_DIGITS−1 < 2^DATA_W.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `newDigit` input 1: decoder flag, digit square under an active click.
- `newOp` input 1: decoder flag, operator/equals square under an active click.
- `clickedMatrix` input 4: decoder code. Digit 0–9, or operator code: 1 = mul, 2 = add, 3 = sub, 4 = div, 14 = equals.
- `calc_req` output 1: operands valid, ALU request.
- `calc_a` output DATA_W: operand A.
- `calc_b` output DATA_W: operand B.
- `calc_op` output 4: operator code (1–4).
- `calc_ack` input 1: ALU result valid; single-cycle pulse.
- `calc_result` input DATA_W: ALU result, sampled when `calc_ack` is high.
- `disp_value` output DATA_W: value to display.
- `busy` output 1: high in state REQ.

## Operation
- **Click event.** `hit = newDigit | newOp`, registered into `hit_q`. An event fires in the cycle where `hit & ~hit_q` is true. `clickedMatrix` is sampled in that same cycle. A held click produces exactly one event. The click must be released (`hit` low for at least one cycle) before the next event can fire.
- **Digit append.** `v <= v*10 + d`, computed as `(v<<3)+(v<<1)+d`, truncated to DATA_W. A per-operand digit counter saturates at MAX_DIGITS. Further digits are ignored.
- **State ENTER_A.**
  - digit: append to A.
  - op 1–4: latch `calc_op`, clear B and its count, go to ENTER_B.
  - equals: ignored.
  - other codes: ignored.
- **State ENTER_B.**
  - digit: append to B.
  - op 1–4: if B count = 0, replace `calc_op`; otherwise ignored.
  - equals: if B count > 0, go to REQ; otherwise ignored.
- **State REQ.**
  - `calc_req` = 1; A, B and op are frozen. All click events are dropped.
  - On `calc_ack`: load `calc_result` into the result register, go to SHOW.
- **State SHOW.**
  - digit: A = digit, A count = 1, go to ENTER_A.
  - op 1–4: A = result, A count = MAX_DIGITS (chaining; no append onto a result), latch op, clear B, go to ENTER_B.
  - equals: ignored.
- **`disp_value` selection.**
  - ENTER_A: A.
  - ENTER_B: B if B count > 0, else A.
  - REQ: A.
  - SHOW: result.
- **Unexpected ack.** `calc_ack` outside REQ is ignored.

## Timing
- All outputs are registered.
- **Reset values.** State ENTER_A. A, B, result, counts, `calc_op`, `hit_q` all 0. `calc_req` 0, `busy` 0, `disp_value` 0.
- **Event latency.** Event detected in cycle t; the operand, state and `disp_value` updates are visible after edge t+1.
- **Request assert.** Equals accepted in cycle t → `calc_req` high from edge t+1.
- **Request hold.** `calc_req` stays high, with A, B and op stable, until the edge on which `calc_ack` is sampled high. It is low from that edge.
- **Ack.** Ack in cycle t → state SHOW and `disp_value` = result after edge t+1.
- **Same-cycle ack.** A `calc_ack` coinciding with the first cycle of `calc_req` is accepted.
- **Reset mid-transaction.** `reset_n` low during REQ deasserts `calc_req` asynchronously and drops the transaction. Any late ack is ignored.
- **Simultaneous flags.** If `newDigit` and `newOp` are both high, `newOp` wins.

## Structure
- **Package `calc_pkg`.**
  - Operator codes: `OP_MUL`=1, `OP_ADD`=2, `OP_SUB`=3, `OP_DIV`=4, `OP_EQ`=14.
  - State enum: ENTER_A, ENTER_B, REQ, SHOW.
  - Digit range constant: 9.
- **Sub-module `click_edge_detect`.** Holds the `hit_q` register and produces the one-cycle event pulse.
- **Top.** The FSM, both operand accumulators with their counters, and the result register stay in the top module.

## Test plan
- **Basic add.** Clicks 1,2,+,3,4,= → `calc_req` = 1 with `calc_a` = 12, `calc_b` = 34, `calc_op` = 2. Ack with result 46 → `disp_value` = 46, `calc_req` = 0.
- **Held click.** Hold digit 7 level for 100 cycles → A = 7, digit count = 1. After release, click 7 again → A = 77.
- **Digit overflow.** Clicks 1,2,3,4,5 → A = 1234 (fifth digit ignored).
- **Chaining.** From SHOW with result 46, click *,2,= → `calc_a` = 46, `calc_b` = 2, `calc_op` = 1.
- **Operator replace and empty equals.** Clicks 7,+,=,−,3,= → first equals ignored (no REQ). Request then carries `calc_op` = 3, A = 7, B = 3.
- **Reset during REQ.** Pull `reset_n` low while `calc_req` = 1 → `calc_req` = 0 immediately, state ENTER_A. An ack arriving after reset release → no change, `disp_value` = 0.
